// File: rtl/sign_extend_if.sv
// Immediate-extender handshake bundle between decode and the extender.
// Decode is the master; the extender is the slave.
interface sign_extend_if #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 16
);
  logic                 in_valid;
  logic                 zero_ext;
  logic [IN_WIDTH-1:0]  immed;
  logic [OUT_WIDTH-1:0] ext_immed;
  logic                 out_valid;

  modport master (
    output in_valid,
    output zero_ext,
    output immed,
    input  ext_immed,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  zero_ext,
    input  immed,
    output ext_immed,
    output out_valid
  );
endinterface

// File: rtl/sign_extend.sv
// Registered immediate extender: widens the decode immediate to the
// datapath width with sign or zero fill, one cycle of latency.
module sign_extend #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  sign_extend_if.slave  bus
);

  logic [OUT_WIDTH-1:0] ext_w;
  logic [OUT_WIDTH-1:0] ext_immed_d;
  logic [OUT_WIDTH-1:0] ext_immed_q;
  logic                 out_valid_d;
  logic                 out_valid_q;

  generate
    if (OUT_WIDTH < IN_WIDTH) begin : g_bad
      $error("sign_extend: OUT_WIDTH must be >= IN_WIDTH");
      assign ext_w = '0;
    end else if (OUT_WIDTH == IN_WIDTH) begin : g_pass
      assign ext_w = bus.immed;
    end else begin : g_ext
      localparam int PAD = OUT_WIDTH - IN_WIDTH;
      logic fill;
      // Fill bit depends only on the immediate MSB and the mode select.
      assign fill  = bus.immed[IN_WIDTH-1] & ~bus.zero_ext;
      assign ext_w = {{PAD{fill}}, bus.immed};
    end
  endgenerate

  always_comb begin
    ext_immed_d = ext_immed_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      ext_immed_d = ext_w;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_immed_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ext_immed_q <= ext_immed_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.ext_immed = ext_immed_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extend.sv
// Bench for sign_extend: vector table plus random stream, with a
// scoreboard queue; a 9->9 instance covers the pass-through case.
module tb_sign_extend;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        ze;
    logic [8:0]  imm;
    logic [15:0] ext;
    logic        vld;
  } vec_t;

  typedef struct {
    logic [15:0] ext;
    logic        vld;
    logic [8:0]  pt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sign_extend_if #(.IN_WIDTH(9), .OUT_WIDTH(16)) bus ();
  sign_extend_if #(.IN_WIDTH(9), .OUT_WIDTH(9))  bus_pt ();

  sign_extend #(.IN_WIDTH(9), .OUT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sign_extend #(.IN_WIDTH(9), .OUT_WIDTH(9)) dut_pt (
    .clk (clk),
    .rst (rst),
    .bus (bus_pt)
  );

  assign bus_pt.in_valid = bus.in_valid;
  assign bus_pt.zero_ext = bus.zero_ext;
  assign bus_pt.immed    = bus.immed;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  vec_t vecs[$];
  logic [8:0]  pt_exp;
  logic [15:0] last_ext;

  task automatic cmp(input string nm, input logic [15:0] a,
                     input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst          = v.rst;
    bus.in_valid = v.iv;
    bus.zero_ext = v.ze;
    bus.immed    = v.imm;
    if (v.rst)     pt_exp = '0;
    else if (v.iv) pt_exp = v.imm;
    e.ext = v.ext;
    e.vld = v.vld;
    e.pt  = pt_exp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty[%0d]: got 0 entries want 1", idx);
    end else begin
      e = sbq.pop_front();
      cmp($sformatf("ext[%0d]", idx), bus.ext_immed, e.ext);
      cmp($sformatf("vld[%0d]", idx), {15'd0, bus.out_valid},
          {15'd0, e.vld});
      cmp($sformatf("pt[%0d]", idx), {7'd0, bus_pt.ext_immed},
          {7'd0, e.pt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [8:0] r_imm;
    logic r_ze, r_iv;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.zero_ext = 1'b0;
    bus.immed    = '0;
    pt_exp       = '0;

    // reset with in_valid high
    vecs.push_back('{1'b1, 1'b1, 1'b0, 9'h1FF, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 9'h1FF, 16'h0000, 1'b0});
    // sign extension
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h000, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h001, 16'h0001, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h100, 16'hFF00, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h1FF, 16'hFFFF, 1'b1});
    // zero extension
    vecs.push_back('{1'b0, 1'b1, 1'b1, 9'h1FF, 16'h01FF, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 9'h100, 16'h0100, 1'b1});
    // MSB clear: both modes agree
    vecs.push_back('{1'b0, 1'b1, 1'b1, 9'h0AB, 16'h00AB, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h0AB, 16'h00AB, 1'b1});
    // hold while idle
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h0FF, 16'h00FF, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 9'h155, 16'h00FF, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 9'h155, 16'h00FF, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 9'h155, 16'h00FF, 1'b0});
    // reset mid-stream
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h1AA, 16'hFFAA, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 9'h1AA, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 9'h1AA, 16'hFFAA, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 16'hFFAA, 1'b0});

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    last_ext = 16'hFFAA;
    for (int i = 0; i < 60; i++) begin
      r_imm = 9'($urandom_range(0, 511));
      r_ze  = 1'($urandom_range(0, 1));
      r_iv  = ($urandom_range(0, 3) != 0);
      if (r_iv) begin
        if (r_ze) last_ext = {7'd0, r_imm};
        else      last_ext = {{7{r_imm[8]}}, r_imm};
      end
      v = '{1'b0, r_iv, r_ze, r_imm, last_ext, r_iv};
      apply(100 + i, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
